// File: rtl/ivector_heard_serializer.sv
// Buffers IVector heard(meth, v) indications in a small FIFO and
// serializes each one as two 32-bit words: meth first, then v.
module ivector_heard_serializer #(
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   heard__ENA,
  input  logic [31:0]            heard_meth,
  input  logic [31:0]            heard_v,
  output logic                   heard__RDY,
  output logic                   out_enq__ENA,
  output logic [31:0]            out_enq_v,
  input  logic                   out_enq__RDY,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CW-1:0]          msg_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    SEND_METH,
    SEND_V
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          xfer;
  logic          pop;
  logic [63:0]   head;

  assign heard__RDY   = !RST && (occ_q != FULL);
  assign accept       = heard__ENA && heard__RDY;
  assign out_enq__ENA = !RST && (occ_q != '0) && out_enq__RDY;
  assign xfer         = out_enq__ENA;
  assign pop          = xfer && (state_q == SEND_V);
  assign head         = mem_q[rd_ptr_q];
  assign out_enq_v    = (state_q == SEND_METH) ? head[63:32] : head[31:0];
  assign occupancy    = occ_q;
  assign msg_count    = cnt_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      state_d = (state_q == SEND_METH) ? SEND_V : SEND_METH;
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q + CW'(1);
    end
    occ_d = occ_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= SEND_METH;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {heard_meth, heard_v};
    end
  end

endmodule
